// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the data memory system-bus port: round-robin with a
// bounded burst lock, and read responses routed back to the issuing master by id.
module dmem_port_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       rdwr,
  input  logic [1:0][3:0]  mask,
  input  logic [1:0][31:0] addr,
  input  logic [1:0][31:0] wr_data,
  output logic [1:0]       gnt,
  output logic [1:0]       rd_valid,
  output logic [31:0]      rd_data,
  output logic             m_en,
  output logic             m_rdwr,
  output logic [3:0]       m_mask,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wr_data,
  input  logic [31:0]      m_rd_data
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          cur;
  logic          oth;
  logic [CW-1:0] cnt;
  logic          keep;
  logic          sel;

  logic [RD_LAT-1:0] rsp_valid;
  logic [RD_LAT-1:0] rsp_id;

  // The holder keeps the port only while it is mid-burst (cnt>0) and under the
  // limit, or when the other master is idle. A tie after an idle cycle therefore
  // goes to the other master, which is why cur resets to 1: master 0 wins first.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves it unassigned would infer a latch.
    gnt  = 2'b00;
    oth  = ~cur;
    keep = req[cur] && (((cnt != '0) && (cnt < CNT_MAX)) || !req[oth]);
    if (keep)          gnt[cur] = 1'b1;
    else if (req[oth]) gnt[oth] = 1'b1;
  end

  assign m_en = |gnt;

  // With no grant the data mux parks on cur so the m_* outputs stay X-free.
  assign sel = m_en ? gnt[1] : cur;

  assign m_rdwr    = rdwr[sel];
  assign m_mask    = mask[sel];
  assign m_addr    = {addr[sel][31:2], 2'b00};
  assign m_wr_data = wr_data[sel];

  // NOTE: sequential state is assigned with non-blocking <= so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= 1'b1;
      cnt <= '0;
    end else if (m_en) begin
      if (sel == cur) begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
      end else begin
        cur <= sel;
        cnt <= CNT_ONE;
      end
    end else begin
      cnt <= '0;
    end
  end

  // NOTE: the response pipeline is reset, not left to power-up values, because
  // a stale valid bit would fire a spurious rd_valid after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_id    <= '0;
    end else begin
      rsp_valid[0] <= m_en & ~m_rdwr;
      rsp_id[0]    <= sel;
      for (int i = 1; i < RD_LAT; i++) begin
        rsp_valid[i] <= rsp_valid[i-1];
        rsp_id[i]    <= rsp_id[i-1];
      end
    end
  end

  assign rd_valid = {rsp_valid[RD_LAT-1] &  rsp_id[RD_LAT-1],
                     rsp_valid[RD_LAT-1] & ~rsp_id[RD_LAT-1]};
  assign rd_data  = m_rd_data;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_req    : assert property (@(posedge clk) disable iff (rst) (gnt & ~req) == 2'b00);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a table of arbitration vectors plus
// hand-written read-response and reset sequences, with a behavioural memory.
module tb_dmem_port_arbiter;

  localparam int MB = 4;
  localparam int RL = 2;
  localparam logic [31:0] WD0 = 32'hAAAA_0000;
  localparam logic [31:0] WD1 = 32'hBBBB_0001;
  localparam logic [31:0] A1C = 32'h0000_2000;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       rdwr;
  logic [1:0][3:0]  mask;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wr_data;
  logic [1:0]       gnt;
  logic [1:0]       rd_valid;
  logic [31:0]      rd_data;
  logic             m_en;
  logic             m_rdwr;
  logic [3:0]       m_mask;
  logic [31:0]      m_addr;
  logic [31:0]      m_wr_data;
  logic [31:0]      m_rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_port_arbiter #(.MAX_BURST(MB), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req(req), .rdwr(rdwr), .mask(mask), .addr(addr),
    .wr_data(wr_data), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .m_en(m_en), .m_rdwr(m_rdwr), .m_mask(m_mask), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_rd_data(m_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: read data appears RL cycles after the read beat.
  logic [31:0] mem_pipe [RL];
  initial for (int i = 0; i < RL; i++) mem_pipe[i] = 32'h0;
  always @(posedge clk) begin
    mem_pipe[0] <= (m_en && !m_rdwr) ? mem_word(m_addr) : 32'h0;
    for (int i = 1; i < RL; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign m_rd_data = mem_pipe[RL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] rw,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [3:0] mk0);
    req     = rq;
    rdwr    = rw;
    addr    = {a1, a0};
    mask    = {4'hF, mk0};
    wr_data = {WD1, WD0};
  endtask

  typedef struct {
    string       name;
    logic [1:0]  req;
    logic [31:0] a0;
    logic [3:0]  mk0;
    logic [1:0]  exp_gnt;
    logic        src;
    logic [31:0] exp_maddr;
  } vec_t;

  function automatic vec_t mkv(input string n, input logic [1:0] rq, input logic [31:0] a0,
                               input logic [3:0] mk0, input logic [1:0] g, input logic src,
                               input logic [31:0] ma);
    vec_t v;
    v.name = n; v.req = rq; v.a0 = a0; v.mk0 = mk0;
    v.exp_gnt = g; v.src = src; v.exp_maddr = ma;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mkv("rst_tie",     2'b11, 32'h1000, 4'hF,    2'b01, 1'b0, 32'h1000);
    tbl[1]  = mkv("burst0_b",    2'b11, 32'h1000, 4'hF,    2'b01, 1'b0, 32'h1000);
    tbl[2]  = mkv("burst0_c",    2'b11, 32'h1000, 4'hF,    2'b01, 1'b0, 32'h1000);
    tbl[3]  = mkv("burst0_d",    2'b11, 32'h1000, 4'hF,    2'b01, 1'b0, 32'h1000);
    tbl[4]  = mkv("burst1_a",    2'b11, 32'h1000, 4'hF,    2'b10, 1'b1, 32'h2000);
    tbl[5]  = mkv("burst1_b",    2'b11, 32'h1000, 4'hF,    2'b10, 1'b1, 32'h2000);
    tbl[6]  = mkv("burst1_c",    2'b11, 32'h1000, 4'hF,    2'b10, 1'b1, 32'h2000);
    tbl[7]  = mkv("burst1_d",    2'b11, 32'h1000, 4'hF,    2'b10, 1'b1, 32'h2000);
    tbl[8]  = mkv("alt0",        2'b11, 32'h1000, 4'hF,    2'b01, 1'b0, 32'h1000);
    tbl[9]  = mkv("idle",        2'b00, 32'h1000, 4'hF,    2'b00, 1'b0, 32'h1000);
    tbl[10] = mkv("lone1",       2'b10, 32'h1000, 4'hF,    2'b10, 1'b1, 32'h2000);
    tbl[11] = mkv("hold1",       2'b11, 32'h1000, 4'hF,    2'b10, 1'b1, 32'h2000);
    tbl[12] = mkv("lone0",       2'b01, 32'h1000, 4'hF,    2'b01, 1'b0, 32'h1000);
    tbl[13] = mkv("align",       2'b01, 32'h0103, 4'b0010, 2'b01, 1'b0, 32'h0100);
    tbl[14] = mkv("sat0_a",      2'b01, 32'h1000, 4'hF,    2'b01, 1'b0, 32'h1000);
    tbl[15] = mkv("sat0_b",      2'b01, 32'h1000, 4'hF,    2'b01, 1'b0, 32'h1000);
    tbl[16] = mkv("sat0_c",      2'b01, 32'h1000, 4'hF,    2'b01, 1'b0, 32'h1000);
    tbl[17] = mkv("sat_handoff", 2'b11, 32'h1000, 4'hF,    2'b10, 1'b1, 32'h2000);

    // Reset held with both masters requesting writes.
    rst = 1'b1;
    drive(2'b11, 2'b11, 32'h1000, A1C, 4'hF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_rd_valid", {30'b0, rd_valid}, 32'h0);
    end

    // Arbitration table, all writes; first vector is the first cycle after release.
    for (int i = 0; i < 18; i++) begin
      next_cycle();
      if (i == 0) rst = 1'b0;
      drive(tbl[i].req, 2'b11, tbl[i].a0, A1C, tbl[i].mk0);
      @(negedge clk);
      check({tbl[i].name, "_gnt"},   {30'b0, gnt}, {30'b0, tbl[i].exp_gnt});
      check({tbl[i].name, "_m_en"},  {31'b0, m_en}, {31'b0, |tbl[i].exp_gnt});
      check({tbl[i].name, "_maddr"}, m_addr, tbl[i].exp_maddr);
      check({tbl[i].name, "_mrdwr"}, {31'b0, m_rdwr}, 32'h1);
      check({tbl[i].name, "_mmask"}, {28'b0, m_mask}, {28'b0, tbl[i].src ? 4'hF : tbl[i].mk0});
      check({tbl[i].name, "_mwdata"}, m_wr_data, tbl[i].src ? WD1 : WD0);
      check({tbl[i].name, "_rdv"},   {30'b0, rd_valid}, 32'h0);
    end

    // Lone master 1: eight reads, then drain.
    for (int k = 0; k < 8 + RL; k++) begin
      next_cycle();
      if (k < 8) drive(2'b10, 2'b00, 32'h1000, 32'h10 + 32'(4 * k), 4'hF);
      else       drive(2'b00, 2'b00, 32'h1000, 32'h10, 4'hF);
      @(negedge clk);
      if (k < 8) begin
        check("lone_rd_gnt",   {30'b0, gnt}, 32'h2);
        check("lone_rd_maddr", m_addr, 32'h10 + 32'(4 * k));
      end
      if (k >= RL) begin
        check("lone_rd_valid", {30'b0, rd_valid}, 32'h2);
        check("lone_rd_data",  rd_data, mem_word(32'h10 + 32'(4 * (k - RL))));
      end else begin
        check("lone_rd_valid", {30'b0, rd_valid}, 32'h0);
      end
    end

    // Back-to-back reads from alternating masters.
    next_cycle();
    drive(2'b01, 2'b00, 32'h0200, 32'h0300, 4'hF);
    @(negedge clk);
    check("alt_rd0_gnt", {30'b0, gnt}, 32'h1);
    next_cycle();
    drive(2'b10, 2'b00, 32'h0200, 32'h0300, 4'hF);
    @(negedge clk);
    check("alt_rd1_gnt", {30'b0, gnt}, 32'h2);
    check("alt_t1_rdv",  {30'b0, rd_valid}, 32'h0);
    next_cycle();
    drive(2'b00, 2'b00, 32'h0200, 32'h0300, 4'hF);
    @(negedge clk);
    check("alt_t2_rdv",  {30'b0, rd_valid}, 32'h1);
    check("alt_t2_data", rd_data, mem_word(32'h0200));
    next_cycle();
    @(negedge clk);
    check("alt_t3_rdv",  {30'b0, rd_valid}, 32'h2);
    check("alt_t3_data", rd_data, mem_word(32'h0300));
    next_cycle();
    @(negedge clk);
    check("alt_t4_rdv",  {30'b0, rd_valid}, 32'h0);

    // Reset pulse one cycle after a read accept drops the in-flight read.
    next_cycle();
    drive(2'b01, 2'b00, 32'h0400, 32'h0300, 4'hF);
    @(negedge clk);
    check("rstpulse_rd_gnt", {30'b0, gnt}, 32'h1);
    next_cycle();
    rst = 1'b1;
    drive(2'b00, 2'b00, 32'h0400, 32'h0300, 4'hF);
    @(negedge clk);
    check("rstpulse_rdv_a", {30'b0, rd_valid}, 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rstpulse_rdv_b", {30'b0, rd_valid}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("rstpulse_rdv_c", {30'b0, rd_valid}, 32'h0);
    next_cycle();
    drive(2'b11, 2'b00, 32'h0500, 32'h0600, 4'hF);
    @(negedge clk);
    check("post_rst_tie_gnt", {30'b0, gnt}, 32'h1);
    check("post_rst_maddr",   m_addr, 32'h0500);
    next_cycle();
    drive(2'b00, 2'b00, 32'h0500, 32'h0600, 4'hF);
    @(negedge clk);
    check("post_rst_rdv_a", {30'b0, rd_valid}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("post_rst_rdv_b", {30'b0, rd_valid}, 32'h1);
    check("post_rst_data",  rd_data, mem_word(32'h0500));
    next_cycle();
    @(negedge clk);
    check("post_rst_rdv_c", {30'b0, rd_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
